// File: rtl/cmd_ctrl.sv
// cmd_ctrl: host command parser that owns the mux enable mask and pin map.
// Commands arrive as single bytes from the UART receiver; read-back responses are
// streamed LSB byte first into the TX FIFO and honour fifo_full backpressure.
// Writes are assembled in a shadow register and committed in one step, so the mux
// never sees a partially written value.
// Optional build macro CMD_CTRL_ACK_EN: queue 0xA5 after every write commit and
// 0xEE after a payload timeout. Without it, writes and timeouts are silent.

module cmd_ctrl #(
    parameter int unsigned OUTPUT_COUNT   = 16,
    parameter int unsigned SEL_WIDTH      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [OUTPUT_COUNT-1:0]           MASK_RESET   = 16'hAA55,
    parameter logic [OUTPUT_COUNT*SEL_WIDTH-1:0] PINMAP_RESET = 32'hAABBCCDD
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rx_valid,
    input  logic [7:0]                        rx_data,
    input  logic                              fifo_full,
    output logic                              fifo_wr_en,
    output logic [7:0]                        fifo_wr_data,
    output logic [OUTPUT_COUNT-1:0]           enabled_out,
    output logic [OUTPUT_COUNT*SEL_WIDTH-1:0] selectors,
    output logic                              busy,
    output logic [7:0]                        err_count
);

    localparam int unsigned MaskW     = OUTPUT_COUNT;
    localparam int unsigned MapW      = OUTPUT_COUNT * SEL_WIDTH;
    localparam int unsigned MaskBytes = MaskW / 8;
    localparam int unsigned MapBytes  = MapW / 8;
    // Shift/shadow registers are sized for the larger of the two registers.
    localparam int unsigned ShW       = (MapW > MaskW) ? MapW : MaskW;
    localparam int unsigned ShBytes   = ShW / 8;
    localparam int unsigned CntW      = $clog2(ShBytes + 1);
    localparam int unsigned TmoW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CntW-1:0] MaskCnt = CntW'(MaskBytes);
    localparam logic [CntW-1:0] MapCnt  = CntW'(MapBytes);
    localparam logic [CntW-1:0] OneCnt  = CntW'(1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);

    localparam logic [7:0] CmdNop      = 8'h00;
    localparam logic [7:0] CmdRdMask   = 8'h01;
    localparam logic [7:0] CmdRdMap    = 8'h02;
    localparam logic [7:0] CmdWrMask   = 8'h03;
    localparam logic [7:0] CmdWrMap    = 8'h04;
`ifdef CMD_CTRL_ACK_EN
    localparam logic [7:0] AckByte     = 8'hA5;
    localparam logic [7:0] TimeoutByte = 8'hEE;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StRxPayload,
        StTxResp
    } state_e;

    state_e            state_q, state_d;
    logic [MaskW-1:0]  mask_q, mask_d;
    logic [MapW-1:0]   map_q, map_d;
    logic [ShW-1:0]    shadow_q, shadow_d;
    logic [ShW-1:0]    tx_shift_q, tx_shift_d;
    logic [CntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              target_map_q, target_map_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        err_q, err_d;
    logic              busy_q, busy_d;
    logic              err_inc;

    // Byte slot in the shadow for the next payload byte (LSB byte first).
    logic [CntW-1:0]   total_cnt;
    logic [CntW-1:0]   wr_idx;

    assign total_cnt = target_map_q ? MapCnt : MaskCnt;
    assign wr_idx    = total_cnt - rx_cnt_q;

    // Next-state logic for the command FSM and all datapath registers.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        map_d        = map_q;
        shadow_d     = shadow_q;
        tx_shift_d   = tx_shift_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        tmo_d        = tmo_q;
        target_map_d = target_map_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        err_inc      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    case (rx_data)
                        CmdRdMask: begin
                            tx_shift_d = ShW'(mask_q);
                            tx_cnt_d   = MaskCnt;
                            state_d    = StTxResp;
                        end
                        CmdRdMap: begin
                            tx_shift_d = ShW'(map_q);
                            tx_cnt_d   = MapCnt;
                            state_d    = StTxResp;
                        end
                        CmdWrMask: begin
                            target_map_d = 1'b0;
                            rx_cnt_d     = MaskCnt;
                            tmo_d        = '0;
                            shadow_d     = '0;
                            state_d      = StRxPayload;
                        end
                        CmdWrMap: begin
                            target_map_d = 1'b1;
                            rx_cnt_d     = MapCnt;
                            tmo_d        = '0;
                            shadow_d     = '0;
                            state_d      = StRxPayload;
                        end
                        CmdNop: begin
                        end
                        default: err_inc = 1'b1;
                    endcase
                end
            end

            StRxPayload: begin
                if (rx_cnt_q == '0) begin
                    // Commit cycle: the whole shadow lands in the target at once.
                    if (target_map_q) begin
                        map_d = shadow_q[MapW-1:0];
                    end else begin
                        mask_d = shadow_q[MaskW-1:0];
                    end
                    shadow_d = '0;
                    state_d  = StIdle;
`ifdef CMD_CTRL_ACK_EN
                    tx_shift_d = ShW'(AckByte);
                    tx_cnt_d   = OneCnt;
                    state_d    = StTxResp;
`endif
                end else if (rx_valid) begin
                    for (int unsigned b = 0; b < ShBytes; b++) begin
                        if (CntW'(b) == wr_idx) begin
                            shadow_d[8*b +: 8] = rx_data;
                        end
                    end
                    rx_cnt_d = rx_cnt_q - OneCnt;
                    tmo_d    = '0;
                end else if (tmo_q == TmoLast) begin
                    // Host went quiet mid-payload: drop everything collected so far.
                    shadow_d = '0;
                    rx_cnt_d = '0;
                    tmo_d    = '0;
                    err_inc  = 1'b1;
                    state_d  = StIdle;
`ifdef CMD_CTRL_ACK_EN
                    tx_shift_d = ShW'(TimeoutByte);
                    tx_cnt_d   = OneCnt;
                    state_d    = StTxResp;
`endif
                end else begin
                    tmo_d = tmo_q + TmoOne;
                end
            end

            StTxResp: begin
                // Bytes arriving while a response is streaming are overruns.
                if (rx_valid) begin
                    err_inc = 1'b1;
                end
                if (!fifo_full) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = tx_shift_q[7:0];
                    tx_shift_d = tx_shift_q >> 8;
                    tx_cnt_d   = tx_cnt_q - OneCnt;
                    if (tx_cnt_q == OneCnt) begin
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        err_d  = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        busy_d = (state_d != StIdle);
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mask_q       <= MASK_RESET;
            map_q        <= PINMAP_RESET;
            shadow_q     <= '0;
            tx_shift_q   <= '0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            tmo_q        <= '0;
            target_map_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 8'h00;
            err_q        <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            map_q        <= map_d;
            shadow_q     <= shadow_d;
            tx_shift_q   <= tx_shift_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            tmo_q        <= tmo_d;
            target_map_q <= target_map_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign enabled_out  = mask_q;
    assign selectors    = map_q;
    assign busy         = busy_q;
    assign err_count    = err_q;

endmodule
